dc_tag_lookup_ctrl: RTL and testbench

Initiator-side controller for a single DC tag bank. It accepts core tag requests, issues a read to the tag bank, and compares the stored tag to decide hit or miss. On a hit it computes the next coherence state and, when that state differs, writes the updated entry back to the bank. It returns hit, old state and new state to the core. It sits between the DC pipeline front end and the tag bank, using the valid/retry handshake on both sides.

---
 rtl/dc_tag_lookup_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dc_tag_lookup_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_tag_lookup_ctrl.sv
// Initiator-side tag lookup controller for one DC tag bank: reads the entry,
// resolves hit/miss, writes back an updated coherence state, and answers the core.
module dc_tag_lookup_ctrl #(
    parameter int Width    = 24,
    parameter int Size     = 32,
    parameter int REQ_BITS = 5,
    localparam int PosW    = $clog2(Size),
    localparam int LoW     = Width - 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_req_valid,
    output logic                core_req_retry,
    input  logic [REQ_BITS-1:0] core_req_type,
    input  logic [PosW-1:0]     core_req_pos,
    input  logic [17:0]         core_req_tag,
    output logic                core_ack_valid,
    input  logic                core_ack_retry,
    output logic                core_ack_hit,
    output logic [2:0]          core_ack_state,
    output logic [2:0]          core_ack_next_state,
    output logic                tb_req_valid,
    input  logic                tb_req_retry,
    output logic                tb_req_we,
    output logic [PosW-1:0]     tb_req_pos,
    output logic [Width-1:0]    tb_req_data,
    input  logic                tb_ack_valid,
    output logic                tb_ack_retry,
    input  logic [Width-1:0]    tb_ack_data
);

    localparam logic [2:0] ST_I  = 3'b000;
    localparam logic [2:0] ST_S  = 3'b001;
    localparam logic [2:0] ST_US = 3'b100;
    localparam logic [2:0] ST_UM = 3'b101;

    localparam logic [REQ_BITS-1:0] MOP_BEGIN   = REQ_BITS'(5'h10);
    localparam logic [REQ_BITS-1:0] MOP_COMMIT  = REQ_BITS'(5'h11);
    localparam logic [REQ_BITS-1:0] MOP_CSYNC   = REQ_BITS'(5'h12);
    localparam logic [REQ_BITS-1:0] MOP_KILL    = REQ_BITS'(5'h13);
    localparam logic [REQ_BITS-1:0] MOP_RESTART = REQ_BITS'(5'h14);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } fsm_e;

    fsm_e                state_q, state_d;
    logic [REQ_BITS-1:0] op_q, op_d;
    logic [PosW-1:0]     pos_q, pos_d;
    logic [17:0]         tag_q, tag_d;
    logic                hit_q, hit_d;
    logic [2:0]          old_q, old_d;
    logic [2:0]          nxt_q, nxt_d;
    logic [LoW-1:0]      lo_q, lo_d;

    logic                rd_hit_s;
    logic [2:0]          rd_old_s;
    logic [2:0]          rd_nxt_s;

    // Coherence transition applied to a hitting entry; loads and unknown ops keep the state.
    function automatic logic [2:0] next_coh(input logic [REQ_BITS-1:0] op,
                                            input logic [2:0] cur);
        logic [2:0] nxt;
        nxt = cur;
        case (op)
            MOP_BEGIN: begin
                if (cur == ST_UM) nxt = ST_US;
                else              nxt = cur;
            end
            MOP_COMMIT, MOP_CSYNC: begin
                if (cur == ST_US) nxt = ST_S;
                else              nxt = cur;
            end
            MOP_KILL, MOP_RESTART: nxt = ST_I;
            default:               nxt = cur;
        endcase
        return nxt;
    endfunction

    // Hit/miss decode of the returned entry against the latched request
    always_comb begin
        rd_old_s = tb_ack_data[Width-1:Width-3];
        rd_hit_s = (tb_ack_data[17:0] == tag_q) && (rd_old_s != ST_I);
        if (rd_hit_s) rd_nxt_s = next_coh(op_q, rd_old_s);
        else          rd_nxt_s = rd_old_s;
    end

    // FSM next state and capture of request and entry fields
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pos_d   = pos_q;
        tag_d   = tag_q;
        hit_d   = hit_q;
        old_d   = old_q;
        nxt_d   = nxt_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (core_req_valid) begin
                    op_d    = core_req_type;
                    pos_d   = core_req_pos;
                    tag_d   = core_req_tag;
                    state_d = RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (!tb_req_retry) state_d = RD_WAIT;
                else               state_d = RD_REQ;
            end
            RD_WAIT: begin
                if (tb_ack_valid) begin
                    hit_d = rd_hit_s;
                    old_d = rd_old_s;
                    nxt_d = rd_nxt_s;
                    lo_d  = tb_ack_data[LoW-1:0];
                    // Only a state change on a hit is worth a bank write
                    if (rd_hit_s && (rd_nxt_s != rd_old_s)) state_d = WR_REQ;
                    else                                     state_d = RESP;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (!tb_req_retry) state_d = RESP;
                else               state_d = WR_REQ;
            end
            RESP: begin
                if (!core_ack_retry) state_d = IDLE;
                else                 state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= {REQ_BITS{1'b0}};
            pos_q   <= {PosW{1'b0}};
            tag_q   <= 18'h0;
            hit_q   <= 1'b0;
            old_q   <= 3'b000;
            nxt_q   <= 3'b000;
            lo_q    <= {LoW{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pos_q   <= pos_d;
            tag_q   <= tag_d;
            hit_q   <= hit_d;
            old_q   <= old_d;
            nxt_q   <= nxt_d;
            lo_q    <= lo_d;
        end
    end

    assign core_req_retry      = reset || (state_q != IDLE);
    assign tb_ack_retry        = reset;
    assign tb_req_valid        = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign tb_req_we           = (state_q == WR_REQ);
    assign tb_req_pos          = pos_q;
    assign tb_req_data         = tb_req_we ? {nxt_q, lo_q} : {Width{1'b0}};
    assign core_ack_valid      = (state_q == RESP);
    assign core_ack_hit        = hit_q;
    assign core_ack_state      = old_q;
    assign core_ack_next_state = nxt_q;

endmodule

// File: tb/tb_dc_tag_lookup_ctrl.sv
// Directed bench for dc_tag_lookup_ctrl: a bank model plus a scoreboard that derives
// expected acks and writes from the coherence rules, cross-checked by literal values.
module tb_dc_tag_lookup_ctrl;

    localparam logic [4:0] OP_L64U    = 5'h03;
    localparam logic [4:0] OP_BEGIN   = 5'h10;
    localparam logic [4:0] OP_COMMIT  = 5'h11;
    localparam logic [4:0] OP_CSYNC   = 5'h12;
    localparam logic [4:0] OP_KILL    = 5'h13;
    localparam logic [4:0] OP_RESTART = 5'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req_valid = 1'b0;
    logic        core_req_retry;
    logic [4:0]  core_req_type = 5'h0;
    logic [4:0]  core_req_pos = 5'h0;
    logic [17:0] core_req_tag = 18'h0;
    logic        core_ack_valid;
    logic        core_ack_retry = 1'b0;
    logic        core_ack_hit;
    logic [2:0]  core_ack_state;
    logic [2:0]  core_ack_next_state;
    logic        tb_req_valid;
    logic        tb_req_retry = 1'b0;
    logic        tb_req_we;
    logic [4:0]  tb_req_pos;
    logic [23:0] tb_req_data;
    logic        tb_ack_valid = 1'b0;
    logic        tb_ack_retry;
    logic [23:0] tb_ack_data = 24'h0;

    dc_tag_lookup_ctrl dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_retry(core_req_retry),
        .core_req_type(core_req_type), .core_req_pos(core_req_pos), .core_req_tag(core_req_tag),
        .core_ack_valid(core_ack_valid), .core_ack_retry(core_ack_retry),
        .core_ack_hit(core_ack_hit), .core_ack_state(core_ack_state),
        .core_ack_next_state(core_ack_next_state),
        .tb_req_valid(tb_req_valid), .tb_req_retry(tb_req_retry), .tb_req_we(tb_req_we),
        .tb_req_pos(tb_req_pos), .tb_req_data(tb_req_data),
        .tb_ack_valid(tb_ack_valid), .tb_ack_retry(tb_ack_retry), .tb_ack_data(tb_ack_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rd = 0, n_wr = 0, n_ack = 0;
    int last_ack_cyc = 0;
    logic [2:0]  last_state, last_next;
    logic        last_hit;
    logic [23:0] last_wr_data;
    logic [4:0]  cur_pos;

    logic [23:0] mem [32];
    logic [6:0]  exp_ack_q[$];
    logic [28:0] exp_wr_q[$];
    bit          bank_mute = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Coherence rule of the spec, evaluated on a hit only
    function automatic logic [2:0] model_next(input logic [4:0] op, input logic [2:0] st);
        if (op == OP_KILL || op == OP_RESTART) return 3'b000;
        if (op == OP_BEGIN && st == 3'b101) return 3'b100;
        if ((op == OP_COMMIT || op == OP_CSYNC) && st == 3'b100) return 3'b001;
        return st;
    endfunction

    // Bank model: one-cycle read latency, writes land on acceptance
    bit          fire = 1'b0, fire_we = 1'b0;
    logic [4:0]  fire_pos;
    logic [23:0] fire_data;
    always @(negedge clk) begin
        fire      = tb_req_valid && !tb_req_retry && !reset;
        fire_we   = tb_req_we;
        fire_pos  = tb_req_pos;
        fire_data = tb_req_data;
    end
    always @(posedge clk) begin
        #1;
        tb_ack_valid = 1'b0;
        tb_ack_data  = 24'h0;
        if (fire) begin
            if (fire_we) mem[fire_pos] = fire_data;
            else if (!bank_mute) begin
                tb_ack_valid = 1'b1;
                tb_ack_data  = mem[fire_pos];
            end
        end
    end

    // Scoreboard compare: transfers and hold-stability on both initiator channels
    bit          req_held = 1'b0, ack_held = 1'b0;
    logic [29:0] req_snap;
    logic [6:0]  ack_snap;
    always @(negedge clk) begin
        if (reset) begin
            req_held = 1'b0;
            ack_held = 1'b0;
        end else begin
            if (req_held)
                chk("tb_req_stable", {tb_req_valid, tb_req_we, tb_req_pos, tb_req_data},
                    {1'b1, req_snap});
            if (ack_held)
                chk("core_ack_stable", {core_ack_valid, core_ack_hit, core_ack_state, core_ack_next_state},
                    {1'b1, ack_snap});
            if (tb_req_valid && !tb_req_retry) begin
                if (tb_req_we) begin
                    n_wr++;
                    last_wr_data = tb_req_data;
                    chk("wr_expected", exp_wr_q.size(), 1);
                    if (exp_wr_q.size() > 0) chk("wr_pos_data", {tb_req_pos, tb_req_data}, exp_wr_q.pop_front());
                end else begin
                    n_rd++;
                    chk("rd_pos_data", {tb_req_pos, tb_req_data}, {cur_pos, 24'h0});
                end
            end
            if (core_ack_valid && !core_ack_retry) begin
                n_ack++;
                last_ack_cyc = cyc;
                last_hit   = core_ack_hit;
                last_state = core_ack_state;
                last_next  = core_ack_next_state;
                chk("ack_expected", exp_ack_q.size(), 1);
                if (exp_ack_q.size() > 0)
                    chk("ack_payload", {core_ack_hit, core_ack_state, core_ack_next_state}, exp_ack_q.pop_front());
            end
            req_held = tb_req_valid && tb_req_retry;
            req_snap = {tb_req_we, tb_req_pos, tb_req_data};
            ack_held = core_ack_valid && core_ack_retry;
            ack_snap = {core_ack_hit, core_ack_state, core_ack_next_state};
        end
    end

    // Present a request, predict its outcome at acceptance, drop valid afterwards
    task automatic send(input logic [4:0] op, input logic [4:0] pos, input logic [17:0] tag,
                        output int acc);
        logic [23:0] e;
        logic        h;
        logic [2:0]  nx;
        core_req_valid = 1'b1;
        core_req_type  = op;
        core_req_pos   = pos;
        core_req_tag   = tag;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!core_req_retry) begin
                acc = cyc;
                break;
            end
        end
        chk("req_accepted", core_req_retry, 1'b0);
        if (acc >= 0) begin
            e  = mem[pos];
            h  = (e[17:0] == tag) && (e[23:21] != 3'b000);
            nx = h ? model_next(op, e[23:21]) : e[23:21];
            exp_ack_q.push_back({h, e[23:21], nx});
            if (h && nx != e[23:21]) exp_wr_q.push_back({pos, nx, e[20:0]});
            cur_pos = pos;
        end
        @(posedge clk);
        #1;
        core_req_valid = 1'b0;
    endtask

    // Wait for the response, check latency, optionally hold core_ack_retry for some cycles
    task automatic finish(input int acc, input int exp_lat, input int hold);
        int seen;
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_ack_valid) begin
                seen = cyc;
                break;
            end
        end
        chk("ack_seen", core_ack_valid, 1'b1);
        if (seen >= 0 && exp_lat >= 0) chk("latency", seen - acc, exp_lat);
        repeat (hold) @(posedge clk);
        #1;
        core_ack_retry = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!core_ack_valid) break;
        end
    endtask

    initial begin
        int acc, acc2, w0, r0, a0;
        for (int i = 0; i < 32; i++) mem[i] = 24'h0;
        mem[5]  = 24'h29ABCD;
        mem[2]  = 24'h980042;
        mem[7]  = 24'h400001;
        mem[8]  = 24'h000055;
        mem[9]  = 24'h77FFFF;
        mem[10] = 24'h400777;
        mem[11] = 24'hA81234;
        mem[12] = 24'h200300;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_core_req_retry", core_req_retry, 1'b1);
        chk("rst_tb_ack_retry", tb_ack_retry, 1'b1);
        chk("rst_valids", {core_ack_valid, tb_req_valid, tb_req_we}, 3'b000);
        chk("rst_payloads", {tb_req_data, core_ack_hit, core_ack_state, core_ack_next_state}, 31'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_core_req_retry", core_req_retry, 1'b0);
        chk("idle_tb_ack_retry", tb_ack_retry, 1'b0);
        @(posedge clk);
        #1;

        // Read hit, state unchanged
        w0 = n_wr;
        send(OP_L64U, 5'd5, 18'h1ABCD, acc);
        finish(acc, 3, 0);
        chk("l64u_ack", {last_hit, last_state, last_next}, {1'b1, 3'b001, 3'b001});
        chk("l64u_no_write", n_wr - w0, 0);

        // MOP_COMMIT on US writes back S with low bits preserved
        send(OP_COMMIT, 5'd2, 18'h00042, acc);
        finish(acc, 4, 0);
        chk("commit_ack", {last_hit, last_state, last_next}, {1'b1, 3'b100, 3'b001});
        chk("commit_wdata", last_wr_data, 24'h380042);

        // Misses: wrong tag, and matching tag in state I
        w0 = n_wr;
        send(OP_KILL, 5'd7, 18'h00002, acc);
        finish(acc, 3, 0);
        chk("miss_tag_ack", {last_hit, last_state, last_next}, {1'b0, 3'b010, 3'b010});
        send(OP_RESTART, 5'd8, 18'h00055, acc);
        finish(acc, 3, 0);
        chk("miss_inv_ack", {last_hit, last_state, last_next}, {1'b0, 3'b000, 3'b000});
        chk("miss_no_write", n_wr - w0, 0);

        // CSYNC on S: hit without state change
        send(OP_CSYNC, 5'd12, 18'h00300, acc);
        finish(acc, 3, 0);
        chk("csync_ack", {last_hit, last_state, last_next}, {1'b1, 3'b001, 3'b001});

        // Back-pressure on both bank request and core response
        r0 = n_rd; w0 = n_wr; a0 = n_ack;
        tb_req_retry   = 1'b1;
        core_ack_retry = 1'b1;
        send(OP_BEGIN, 5'd11, 18'h01234, acc);
        repeat (3) @(posedge clk);
        #1;
        tb_req_retry = 1'b0;
        finish(acc, -1, 2);
        chk("bp_counts", {n_rd - r0, n_wr - w0, n_ack - a0}, {32'd1, 32'd1, 32'd1});
        chk("bp_ack", {last_hit, last_state, last_next}, {1'b1, 3'b101, 3'b100});
        chk("bp_wdata", last_wr_data, 24'h881234);

        // Reset while waiting for the bank: request dropped, no write
        w0 = n_wr; a0 = n_ack; r0 = n_rd;
        bank_mute = 1'b1;
        send(OP_KILL, 5'd10, 18'h00777, acc);
        for (int i = 0; i < 20; i++) begin
            if (n_rd != r0) break;
            @(negedge clk);
        end
        chk("mid_rd_issued", n_rd - r0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_retries", {core_req_retry, tb_ack_retry}, 2'b11);
        @(posedge clk);
        #1;
        exp_ack_q.delete();
        exp_wr_q.delete();
        bank_mute = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valids", {core_ack_valid, tb_req_valid, tb_req_we, tb_req_data}, 27'h0);
        repeat (5) @(negedge clk);
        chk("mid_rst_no_wr_ack", {n_wr - w0, n_ack - a0}, 64'h0);
        chk("mid_rst_mem", mem[10], 24'h400777);
        @(posedge clk);
        #1;

        // KILL on M, followed back-to-back by a second request to the same set
        send(OP_KILL, 5'd9, 18'h3FFFF, acc);
        send(OP_L64U, 5'd9, 18'h3FFFF, acc2);
        chk("kill_ack", {last_hit, last_state, last_next}, {1'b1, 3'b011, 3'b000});
        chk("kill_wdata", last_wr_data, 24'h17FFFF);
        chk("b2b_accept_after_ack", acc2 - last_ack_cyc, 1);
        chk("kill_latency", last_ack_cyc - acc, 4);
        finish(acc2, 3, 0);
        chk("after_kill_ack", {last_hit, last_state, last_next}, {1'b0, 3'b000, 3'b000});
        chk("queues_drained", exp_ack_q.size() + exp_wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
